// File: rtl/acq_sequencer.sv
// acq_sequencer -- disc-capture acquisition sequencer.
//
// Accepts a start request, optionally arms on an index edge, runs the reader
// datapath until an index count, FIFO-full or abort ends the capture, then
// flushes for FLUSH_CLKS cycles and pulses done.
//
// Ports
//   clock           system clock, rising edge
//   reset           synchronous active-high reset
//   start           one-cycle start request (honoured in IDLE only)
//   abort           one-cycle abort request (honoured in ARM/ACQ only)
//   wait_index      1 = arm on an index edge before running (sampled on start)
//   stop_index_cnt  index edges that end the capture, 0 = none (sampled on start)
//   fd_index_in     index signal, already synchronised to clock
//   fifo_full       capture FIFO full flag
//   run             run enable to the reader datapath (high exactly in ACQ)
//   busy            high in any state other than IDLE
//   waiting         high only in ARM
//   done            one-cycle pulse when FLUSH completes
//   stop_reason     00 none, 01 index count, 10 FIFO full, 11 abort
//   index_count     index edges seen in ACQ, saturating at 255
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | waiting for start
// ST_ARM   | waiting for the arming index edge (not counted)
// ST_ACQ   | capturing, run high, counting index edges
// ST_FLUSH | run low for FLUSH_CLKS cycles, then done and back to idle

module acq_sequencer #(
   parameter int FLUSH_CLKS = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       wait_index,
   input  logic [7:0] stop_index_cnt,
   input  logic       fd_index_in,
   input  logic       fifo_full,
   output logic       run,
   output logic       busy,
   output logic       waiting,
   output logic       done,
   output logic [1:0] stop_reason,
   output logic [7:0] index_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_ACQ   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic [1:0] SR_NONE  = 2'b00;
   localparam logic [1:0] SR_INDEX = 2'b01;
   localparam logic [1:0] SR_FULL  = 2'b10;
   localparam logic [1:0] SR_ABORT = 2'b11;

   // Down-counter reload: counts FLUSH_LOAD..0, i.e. FLUSH_CLKS cycles in FLUSH.
   localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CLKS - 1);

   state_t     state, state_nxt;
   logic [7:0] stop_cnt_q, stop_cnt_nxt;
   logic [7:0] flush_cnt, flush_cnt_nxt;
   logic [7:0] index_count_nxt;
   logic [1:0] stop_reason_nxt;
   logic       done_nxt;
   logic       idx_prev;
   logic       idx_edge;
   logic       cnt_hit;
   logic [7:0] cnt_inc;

   assign idx_edge = fd_index_in & ~idx_prev;
   assign cnt_inc  = (idx_edge && (index_count != 8'hFF)) ? index_count + 8'd1 : index_count;
   // 9-bit sum so a saturated count plus an edge can never alias onto a small target.
   assign cnt_hit  = (stop_cnt_q != 8'd0) &&
                     (({1'b0, index_count} + {8'd0, idx_edge}) == {1'b0, stop_cnt_q});

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         stop_cnt_q  <= 8'd0;
         flush_cnt   <= 8'd0;
         idx_prev    <= 1'b0;
         run         <= 1'b0;
         busy        <= 1'b0;
         waiting     <= 1'b0;
         done        <= 1'b0;
         stop_reason <= SR_NONE;
         index_count <= 8'd0;
      end else begin
         state       <= state_nxt;
         stop_cnt_q  <= stop_cnt_nxt;
         flush_cnt   <= flush_cnt_nxt;
         idx_prev    <= fd_index_in;
         run         <= (state_nxt == ST_ACQ);
         busy        <= (state_nxt != ST_IDLE);
         waiting     <= (state_nxt == ST_ARM);
         done        <= done_nxt;
         stop_reason <= stop_reason_nxt;
         index_count <= index_count_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      stop_cnt_nxt    = stop_cnt_q;
      flush_cnt_nxt   = flush_cnt;
      index_count_nxt = index_count;
      stop_reason_nxt = stop_reason;
      done_nxt        = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               stop_cnt_nxt    = stop_index_cnt;
               index_count_nxt = 8'd0;
               stop_reason_nxt = SR_NONE;
               state_nxt       = wait_index ? ST_ARM : ST_ACQ;
            end
         end

         ST_ARM: begin
            if (abort) begin
               stop_reason_nxt = SR_ABORT;
               flush_cnt_nxt   = FLUSH_LOAD;
               state_nxt       = ST_FLUSH;
            end else if (idx_edge) begin
               state_nxt = ST_ACQ;
            end
         end

         ST_ACQ: begin
            index_count_nxt = cnt_inc;
            if (abort || fifo_full || cnt_hit) begin
               flush_cnt_nxt = FLUSH_LOAD;
               state_nxt     = ST_FLUSH;
               if (abort)
                  stop_reason_nxt = SR_ABORT;
               else if (fifo_full)
                  stop_reason_nxt = SR_FULL;
               else
                  stop_reason_nxt = SR_INDEX;
            end
         end

         ST_FLUSH: begin
            if (flush_cnt == 8'd0) begin
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               flush_cnt_nxt = flush_cnt - 8'd1;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_acq_sequencer.sv
module tb_acq_sequencer;

   localparam int FLUSH_CLKS = 8;

   logic       clock = 1'b0;
   logic       reset, start, abort, wait_index, fd_index_in, fifo_full;
   logic [7:0] stop_index_cnt;
   logic       run, busy, waiting, done;
   logic [1:0] stop_reason;
   logic [7:0] index_count;

   int checks = 0;
   int errors = 0;

   acq_sequencer #(.FLUSH_CLKS(FLUSH_CLKS)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .wait_index     (wait_index),
      .stop_index_cnt (stop_index_cnt),
      .fd_index_in    (fd_index_in),
      .fifo_full      (fifo_full),
      .run            (run),
      .busy           (busy),
      .waiting        (waiting),
      .done           (done),
      .stop_reason    (stop_reason),
      .index_count    (index_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst, start, abort, wi;
      logic [7:0] sc;
      logic       idx, ff;
      int         reps;
      logic       run, busy, waiting, done;
      logic [1:0] sr;
      logic [7:0] ic;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      reset = 1'b0; start = 1'b0; abort = 1'b0; wait_index = 1'b0;
      stop_index_cnt = 8'd0; fd_index_in = 1'b0; fifo_full = 1'b0;
   endtask

   task automatic add(input int rst, input int st, input int ab, input int wi, input int sc,
                      input int idx, input int ff, input int reps,
                      input int e_run, input int e_busy, input int e_wait, input int e_done,
                      input int e_sr, input int e_ic);
      vec_t v;
      v.rst = 1'(rst); v.start = 1'(st); v.abort = 1'(ab); v.wi = 1'(wi);
      v.sc = 8'(sc); v.idx = 1'(idx); v.ff = 1'(ff); v.reps = reps;
      v.run = 1'(e_run); v.busy = 1'(e_busy); v.waiting = 1'(e_wait); v.done = 1'(e_done);
      v.sr = 2'(e_sr); v.ic = 8'(e_ic);
      vecs.push_back(v);
   endtask

   task automatic do_start(input logic wi, input logic [7:0] sc);
      wait_index = wi; stop_index_cnt = sc; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (done === 1'b1) seen = 1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   initial begin
      clear_inputs();

      //   rst st ab wi sc idx ff reps | run busy wait done sr ic
      add(1, 0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 2, 0, 0, 1,   0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 2, 0, 0, 1,   1, 1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 1,   1, 1, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1, 0, 1,   1, 1, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 1);
      add(0, 1, 0, 0, 5, 0, 0, 1,   1, 1, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1, 0, 1,   0, 1, 0, 0, 1, 2);
      add(0, 1, 1, 0, 0, 0, 1, 7,   0, 1, 0, 0, 1, 2);
      add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 2);
      add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 2);
      add(0, 1, 0, 1, 1, 0, 0, 1,   0, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 3,   0, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 1,   1, 1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 2, 0);
      add(0, 0, 0, 0, 0, 0, 0, 7,   0, 1, 0, 0, 2, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 2, 0);
      add(0, 1, 0, 1, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 3, 0);
      add(0, 0, 0, 0, 0, 0, 0, 7,   0, 1, 0, 0, 3, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 3, 0);
      add(0, 1, 0, 0, 3, 0, 0, 1,   1, 1, 0, 0, 0, 0);
      add(1, 1, 0, 0, 3, 1, 0, 1,   0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         reset = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
         wait_index = vecs[i].wi; stop_index_cnt = vecs[i].sc;
         fd_index_in = vecs[i].idx; fifo_full = vecs[i].ff;
         repeat (vecs[i].reps) tick();
         check($sformatf("vec%0d run", i),     32'(run),         32'(vecs[i].run));
         check($sformatf("vec%0d busy", i),    32'(busy),        32'(vecs[i].busy));
         check($sformatf("vec%0d waiting", i), 32'(waiting),     32'(vecs[i].waiting));
         check($sformatf("vec%0d done", i),    32'(done),        32'(vecs[i].done));
         check($sformatf("vec%0d stop", i),    32'(stop_reason), 32'(vecs[i].sr));
         check($sformatf("vec%0d count", i),   32'(index_count), 32'(vecs[i].ic));
      end
      clear_inputs();
      tick();

      // Immediate start, two index pulses 100 clocks apart.
      begin
         int early_done = 0;
         do_start(1'b0, 8'd2);
         check("imm run after start", 32'(run), 32'd1);
         fd_index_in = 1'b1; tick(); fd_index_in = 1'b0;
         check("imm count 1", 32'(index_count), 32'd1);
         check("imm run after edge 1", 32'(run), 32'd1);
         repeat (99) tick();
         fd_index_in = 1'b1; tick(); fd_index_in = 1'b0;
         check("imm count 2", 32'(index_count), 32'd2);
         check("imm run dropped", 32'(run), 32'd0);
         check("imm stop reason", 32'(stop_reason), 32'd1);
         for (int i = 1; i <= FLUSH_CLKS; i++) begin
            tick();
            if (i < FLUSH_CLKS && done === 1'b1) early_done++;
         end
         check("imm early done", 32'(early_done), 32'd0);
         check("imm done after flush", 32'(done), 32'd1);
         tick();
      end

      // Armed start: arming edge at t=50, stopping edge at t=300.
      begin
         int bad = 0;
         do_start(1'b1, 8'd1);
         for (int t = 1; t < 50; t++) begin
            if (waiting !== 1'b1 || run !== 1'b0) bad++;
            tick();
         end
         if (waiting !== 1'b1 || run !== 1'b0) bad++;
         check("arm waiting before edge", 32'(bad), 32'd0);
         fd_index_in = 1'b1; tick(); fd_index_in = 1'b0;
         check("arm run at t51", 32'(run), 32'd1);
         check("arm waiting cleared", 32'(waiting), 32'd0);
         check("arm edge not counted", 32'(index_count), 32'd0);
         bad = 0;
         for (int t = 51; t < 300; t++) begin
            tick();
            if (run !== 1'b1) bad++;
         end
         check("arm run held", 32'(bad), 32'd0);
         fd_index_in = 1'b1; tick(); fd_index_in = 1'b0;
         check("arm run dropped", 32'(run), 32'd0);
         check("arm count", 32'(index_count), 32'd1);
         check("arm stop reason", 32'(stop_reason), 32'd1);
         wait_done("arm done");
         tick();
      end

      // FIFO-full stop with no index stop.
      begin
         int dones = 0;
         do_start(1'b0, 8'd0);
         repeat (40) tick();
         check("full run before", 32'(run), 32'd1);
         fifo_full = 1'b1; tick(); fifo_full = 1'b0;
         check("full run dropped", 32'(run), 32'd0);
         check("full stop reason", 32'(stop_reason), 32'd2);
         for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) dones++;
         end
         check("full done pulses", 32'(dones), 32'd1);
         check("full idle after", 32'(busy), 32'd0);
      end

      // Collision of abort, FIFO-full and the final index edge.
      do_start(1'b0, 8'd2);
      fd_index_in = 1'b1; tick(); fd_index_in = 1'b0; tick();
      check("coll count 1", 32'(index_count), 32'd1);
      fd_index_in = 1'b1; abort = 1'b1; fifo_full = 1'b1;
      tick();
      clear_inputs();
      check("coll stop reason", 32'(stop_reason), 32'd3);
      check("coll count 2", 32'(index_count), 32'd2);
      check("coll run", 32'(run), 32'd0);
      check("coll busy", 32'(busy), 32'd1);
      wait_done("coll done");
      tick();

      // Reset mid-ACQ and mid-FLUSH: no done pulse afterwards.
      for (int k = 0; k < 2; k++) begin
         int dones = 0;
         do_start(1'b0, 8'd0);
         fd_index_in = 1'b1; tick(); fd_index_in = 1'b0; tick();
         if (k == 1) begin
            fifo_full = 1'b1; tick(); fifo_full = 1'b0;
            repeat (3) tick();
         end
         reset = 1'b1; tick(); reset = 1'b0;
         check($sformatf("rst%0d run", k),     32'(run),         32'd0);
         check($sformatf("rst%0d busy", k),    32'(busy),        32'd0);
         check($sformatf("rst%0d waiting", k), 32'(waiting),     32'd0);
         check($sformatf("rst%0d stop", k),    32'(stop_reason), 32'd0);
         check($sformatf("rst%0d count", k),   32'(index_count), 32'd0);
         for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy !== 1'b0) dones++;
            tick();
         end
         check($sformatf("rst%0d quiet", k), 32'(dones), 32'd0);
      end

      // Index count saturation with no index stop.
      do_start(1'b0, 8'd0);
      for (int i = 0; i < 300; i++) begin
         fd_index_in = 1'b1; tick(); fd_index_in = 1'b0; tick();
         if (i == 99) check("sat count 100", 32'(index_count), 32'd100);
      end
      check("sat count 255", 32'(index_count), 32'd255);
      check("sat run", 32'(run), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      check("sat abort reason", 32'(stop_reason), 32'd3);
      wait_done("sat done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
